// File: rtl/text_console_buffer.sv
// Character buffer with hardware cursor, scroll-up on overflow and hardware clear.
// Optional cursor blink overlay on the read port is enabled with `define CURSOR_BLINK_EN.
module text_console_buffer #(
    parameter int          COLS         = 16,
    parameter int          ROWS         = 4,
    parameter int          RD_ADDR_W    = 8,
    parameter logic [7:0]  FILL_CHAR    = 8'h20,
    parameter int          BLINK_CYCLES = 6000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [7:0]                  wr_char,
    input  logic [RD_ADDR_W-1:0]        char_addr,
    output logic [7:0]                  char_out,
    output logic                        busy,
    output logic [$clog2(ROWS)-1:0]     cursor_row,
    output logic [$clog2(COLS)-1:0]     cursor_col
);

    localparam int CELLS      = ROWS * COLS;
    localparam int AW         = $clog2(CELLS);
    localparam int IDX_W      = AW + 1;
    localparam int ROW_W      = $clog2(ROWS);
    localparam int COL_W      = $clog2(COLS);
    localparam int SCROLL_LEN = COLS * (ROWS - 1);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    generate
        if (COLS < 2 || ROWS < 2 || (2 ** RD_ADDR_W) < CELLS || BLINK_CYCLES < 1) begin : g_param_check
            $error("text_console_buffer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_FILL_ROW,
        ST_CLEAR
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [ROW_W-1:0]   row_n;
    logic [COL_W-1:0]   col_n;
    logic [IDX_W-1:0]   cur_idx;
    logic [AW-1:0]      src;
    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [7:0]         wdata;
    logic [7:0]         rd_data;
    logic               addr_in_range;

    logic [7:0] mem [2 ** AW];

    assign cur_idx  = IDX_W'(cursor_row) * IDX_W'(COLS) + IDX_W'(cursor_col);
    assign src      = idx[AW-1:0] + AW'(COLS);
    assign wr_ready = (state == ST_IDLE);
    assign busy     = ~wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            idx        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        row_n   = cursor_row;
        col_n   = cursor_col;
        we      = 1'b0;
        waddr   = idx;
        wdata   = FILL_CHAR;
        case (state)
            ST_IDLE: begin
                if (wr_valid) begin
                    if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cur_idx;
                        wdata = wr_char;
                        if (cursor_col != LAST_COL) begin
                            col_n = cursor_col + COL_W'(1);
                        end else begin
                            col_n = '0;
                            if (cursor_row != LAST_ROW) begin
                                row_n = cursor_row + ROW_W'(1);
                            end else begin
                                state_n = ST_SCROLL;
                                idx_n   = '0;
                            end
                        end
                    end else begin
                        case (wr_char)
                            8'h0A: begin
                                col_n = '0;
                                if (cursor_row != LAST_ROW) begin
                                    row_n = cursor_row + ROW_W'(1);
                                end else begin
                                    state_n = ST_SCROLL;
                                    idx_n   = '0;
                                end
                            end
                            8'h0D: col_n = '0;
                            8'h08: begin
                                if (cursor_col != '0) begin
                                    col_n = cursor_col - COL_W'(1);
                                    we    = 1'b1;
                                    waddr = cur_idx - IDX_W'(1);
                                end
                            end
                            8'h0C: begin
                                row_n   = '0;
                                col_n   = '0;
                                state_n = ST_CLEAR;
                                idx_n   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // FILL_ROW continues the same index, so the scroll ends at the last cell.
            ST_SCROLL: begin
                we    = 1'b1;
                wdata = mem[src];
                if (idx == IDX_W'(SCROLL_LEN - 1)) begin
                    state_n = ST_FILL_ROW;
                end
                idx_n = idx + IDX_W'(1);
            end
            ST_FILL_ROW, ST_CLEAR: begin
                we = 1'b1;
                if (idx == IDX_W'(CELLS - 1)) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && waddr < IDX_W'(CELLS)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign addr_in_range = ({1'b0, char_addr} < (RD_ADDR_W + 1)'(CELLS));
    assign rd_data       = addr_in_range ? mem[char_addr[AW-1:0]] : FILL_CHAR;

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES) + 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          show_cursor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign show_cursor = blink_phase && (state == ST_IDLE) &&
                         (32'(char_addr) == 32'(cur_idx));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_out <= FILL_CHAR;
        end else begin
            char_out <= show_cursor ? 8'h5F : rd_data;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_out <= FILL_CHAR;
        end else begin
            char_out <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_text_console_buffer.sv
// Directed self-checking bench for text_console_buffer at default geometry (16x4).
module tb_text_console_buffer;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic [7:0] char_addr;
    logic [7:0] char_out;
    logic       busy;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;

    int checks   = 0;
    int failures = 0;

    text_console_buffer #(
        .COLS(16), .ROWS(4), .RD_ADDR_W(8), .FILL_CHAR(8'h20), .BLINK_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_char(wr_char), .char_addr(char_addr), .char_out(char_out),
        .busy(busy), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("send_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_char  = c;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic read_cell(input int a, output logic [7:0] v);
        char_addr = 8'(a);
        @(negedge clk);
        v = char_out;
    endtask

    task automatic check_cursor(input string tag, input int r, input int c);
        check_output({tag, "_row"}, 32'(cursor_row), 32'(r));
        check_output({tag, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] samples [16];
        int n;

        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_char   = 8'h00;
        char_addr = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd1);
        check_output("rst_char_out", 32'(char_out), 32'h20);
        check_cursor("rst_cursor", 0, 0);

        // Reset release: full clear, then every cell reads blank.
        reset = 1'b0;
        wait_ready(n);
        check_output("clear_cycles", 32'(n), 32'd64);
        check_output("clear_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 64; i++) begin
            read_cell(i, v);
            check_output("clear_cell", 32'(v), 32'h20);
        end
        read_cell(200, v);
        check_output("addr200", 32'(v), 32'h20);

        send_char(8'h41);
        send_char(8'h42);
        send_char(8'h0A);
        send_char(8'h43);
        check_cursor("wr_cursor", 1, 1);
        read_cell(0, v);  check_output("wr_cell0", 32'(v), 32'h41);
        read_cell(1, v);  check_output("wr_cell1", 32'(v), 32'h42);
        read_cell(16, v); check_output("wr_cell16", 32'(v), 32'h43);

        send_char(8'h08);
        check_cursor("bs1_cursor", 1, 0);
        read_cell(16, v); check_output("bs_cell16", 32'(v), 32'h20);
        send_char(8'h08);
        check_cursor("bs2_cursor", 1, 0);
        read_cell(0, v);  check_output("bs_cell0_kept", 32'(v), 32'h41);

        // Form feed with wr_valid held through the busy window.
        wr_valid = 1'b1;
        wr_char  = 8'h0C;
        @(negedge clk);
        wr_char = 8'h5A;
        check_output("ff_busy", 32'(busy), 32'd1);
        wait_ready(n);
        check_output("ff_cycles", 32'(n), 32'd64);
        check_cursor("ff_cursor", 0, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        check_cursor("ff_held_cursor", 0, 1);
        read_cell(0, v);  check_output("ff_held_cell0", 32'(v), 32'h5A);
        read_cell(16, v); check_output("ff_cell16", 32'(v), 32'h20);
        read_cell(63, v); check_output("ff_cell63", 32'(v), 32'h20);

        send_char(8'h0C);
        wait_ready(n);
        check_output("ff2_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 63; i++) begin
            send_char(8'(8'h30 + (i % 10)));
        end
        check_cursor("fill63_cursor", 3, 15);
        check_output("fill63_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_char  = 8'h33;
        @(negedge clk);
        wr_valid = 1'b0;
        check_output("scroll_ready_low", 32'(wr_ready), 32'd0);
        check_cursor("scroll_cursor", 3, 0);
        wait_ready(n);
        check_output("scroll_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            read_cell(i, v);
            check_output("scroll_cell", 32'(v), (i < 48) ? 32'(8'h30 + ((i + 16) % 10)) : 32'h20);
        end
        read_cell(72, v);
        check_output("addr72_oor", 32'(v), 32'h20);

        send_char(8'h51);
        check_cursor("q_cursor", 3, 1);
        send_char(8'h0D);
        check_cursor("cr_cursor", 3, 0);
        send_char(8'h01);
        send_char(8'h7F);
        send_char(8'hFF);
        check_cursor("ign_cursor", 3, 0);
        check_output("ign_ready", 32'(wr_ready), 32'd1);
        read_cell(48, v); check_output("q_cell48", 32'(v), 32'h51);

        send_char(8'h0A);
        check_output("lf_scroll_ready", 32'(wr_ready), 32'd0);
        check_cursor("lf_scroll_cursor", 3, 0);
        wait_ready(n);
        check_output("lf_scroll_cycles", 32'(n), 32'd64);
        read_cell(32, v); check_output("lf_cell32", 32'(v), 32'h51);
        read_cell(48, v); check_output("lf_cell48", 32'(v), 32'h20);
        read_cell(0, v);  check_output("lf_cell0", 32'(v), 32'h32);
        read_cell(16, v); check_output("lf_cell16", 32'(v), 32'h38);

        // Reset ten cycles into a scroll.
        char_addr = 8'd0;
        send_char(8'h0A);
        repeat (10) @(negedge clk);
        check_output("mid_scroll_cell0", 32'(char_out), 32'h38);
        check_output("mid_scroll_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_ready", 32'(wr_ready), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd1);
        check_output("mid_rst_char_out", 32'(char_out), 32'h20);
        check_cursor("mid_rst_cursor", 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n);
        check_output("mid_rst_clear_cycles", 32'(n), 32'd64);
        read_cell(16, v); check_output("post_rst_cell16", 32'(v), 32'h20);
        read_cell(32, v); check_output("post_rst_cell32", 32'(v), 32'h20);

        char_addr = 8'd0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            samples[i] = char_out;
        end
`ifdef CURSOR_BLINK_EN
        for (int i = 0; i < 16; i++) begin
            check_output("blink_value", 32'(samples[i] == 8'h5F || samples[i] == 8'h20), 32'd1);
        end
        for (int i = 0; i < 12; i++) begin
            check_output("blink_toggle", 32'(samples[i + 4] != samples[i]), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            check_output("blink_period", 32'(samples[i + 8]), 32'(samples[i]));
        end
`else
        for (int i = 0; i < 16; i++) begin
            check_output("no_blink", 32'(samples[i]), 32'h20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
